// File: rtl/z80_regfile_banked.sv
// Banked Z80 register file: BC/DE/HL and AF are renamed by bank pointers,
// plus unbanked I/R/IX/IY/SP/PC/WZ, one 8-bit and one pair read port.
module z80_regfile_banked #(
  parameter int REG_W     = 8,
  parameter int NUM_BANKS = 2,
  parameter int BYPASS    = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic                          wr_16,
  input  logic [3:0]                    wr_sel,
  input  logic [2:0]                    wr_psel,
  input  logic [2*REG_W-1:0]            wr_data,
  input  logic [3:0]                    rd_sel,
  output logic [REG_W-1:0]              rd_data,
  input  logic [2:0]                    rd_psel,
  output logic [2*REG_W-1:0]            rd_pdata,
  input  logic                          ex_af,
  input  logic                          exx,
  input  logic                          inc_r,
  input  logic                          sp_inc,
  input  logic                          sp_dec,
  input  logic                          pc_ld,
  input  logic                          pc_inc,
  output logic [2*REG_W-1:0]            pc_out,
  output logic [$clog2(NUM_BANKS)-1:0]  bank_id,
  output logic [$clog2(NUM_BANKS)-1:0]  af_bank_id
);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int PW = 2 * REG_W;
  // byte selects that take the high half of a pair write
  localparam logic [15:0] HI_MASK = 16'h5495;

  function automatic logic [3:0] pair_hi(input logic [2:0] p);
    case (p)
      3'd0:    pair_hi = 4'd0;
      3'd1:    pair_hi = 4'd2;
      3'd2:    pair_hi = 4'd4;
      3'd4:    pair_hi = 4'd7;
      3'd5:    pair_hi = 4'd10;
      3'd6:    pair_hi = 4'd12;
      3'd7:    pair_hi = 4'd14;
      default: pair_hi = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] pair_lo(input logic [2:0] p);
    case (p)
      3'd0:    pair_lo = 4'd1;
      3'd1:    pair_lo = 4'd3;
      3'd2:    pair_lo = 4'd5;
      3'd4:    pair_lo = 4'd6;
      3'd5:    pair_lo = 4'd11;
      3'd6:    pair_lo = 4'd13;
      3'd7:    pair_lo = 4'd15;
      default: pair_lo = 4'd1;
    endcase
  endfunction

  logic [5:0][REG_W-1:0]  main_q [NUM_BANKS];
  logic [1:0][REG_W-1:0]  af_q   [NUM_BANKS];
  logic [7:0][REG_W-1:0]  ub_q;
  logic [PW-1:0]          sp_q, pc_q;
  logic [BW-1:0]          bank_q, afb_q;

  logic [15:0]            wb;
  logic                   wsp;
  logic [15:0][REG_W-1:0] wd, cur, view;

  always_comb begin
    wb  = '0;
    wsp = 1'b0;
    if (wr_en) begin
      if (!wr_16)             wb[wr_sel] = 1'b1;
      else if (wr_psel == 3'd3) wsp = 1'b1;
      else begin
        wb[pair_hi(wr_psel)] = 1'b1;
        wb[pair_lo(wr_psel)] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 16; k++)
      wd[k] = (wr_16 && HI_MASK[k]) ? wr_data[PW-1:REG_W] : wr_data[REG_W-1:0];
  end

  // byte view of the currently selected banks, then the bypass overlay
  always_comb begin
    for (int k = 0; k < 6; k++) cur[k] = main_q[bank_q][k];
    cur[6] = af_q[afb_q][0];
    cur[7] = af_q[afb_q][1];
    for (int k = 0; k < 8; k++) cur[8+k] = ub_q[k];
    for (int k = 0; k < 16; k++)
      view[k] = (BYPASS != 0 && wb[k]) ? wd[k] : cur[k];
  end

  assign rd_data  = view[rd_sel];
  assign rd_pdata = (rd_psel == 3'd3) ? ((BYPASS != 0 && wsp) ? wr_data : sp_q)
                                      : {view[pair_hi(rd_psel)], view[pair_lo(rd_psel)]};
  assign pc_out     = pc_q;
  assign bank_id    = bank_q;
  assign af_bank_id = afb_q;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [5:0][REG_W-1:0] m;
    logic [1:0][REG_W-1:0] af;
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        m  <= '0;
        af <= '1;
      end else begin
        if (bank_q == BW'(b))
          for (int k = 0; k < 6; k++) if (wb[k]) m[k] <= wd[k];
        if (afb_q == BW'(b))
          for (int k = 0; k < 2; k++) if (wb[6+k]) af[k] <= wd[6+k];
      end
    end
    assign main_q[b] = m;
    assign af_q[b]   = af;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ub_q   <= '0;
      sp_q   <= '1;
      pc_q   <= '0;
      bank_q <= '0;
      afb_q  <= '0;
    end else begin
      for (int k = 0; k < 8; k++) if (wb[8+k]) ub_q[k] <= wd[8+k];
      // refresh counts only the low bits; an explicit write to R takes priority
      if (!wb[9] && inc_r)
        ub_q[1] <= {ub_q[1][REG_W-1], ub_q[1][REG_W-2:0] + (REG_W-1)'(1)};
      if (wsp)                  sp_q <= wr_data;
      else if (sp_inc && !sp_dec) sp_q <= sp_q + PW'(1);
      else if (sp_dec && !sp_inc) sp_q <= sp_q - PW'(1);
      if (pc_ld)       pc_q <= wr_data;
      else if (pc_inc) pc_q <= pc_q + PW'(1);
      bank_q <= bank_q + BW'(exx);
      afb_q  <= afb_q + BW'(ex_af);
    end
  end
endmodule
